xnor_cmp_sched: RTL and testbench
=================================

Name: xnor_cmp_sched

Overview:
- Bit-serial equality comparator shared between two requesters through a round-robin arbiter.
- Owns one NOR-only XNOR cell and sequences it over WIDTH operand bits, one bit per clock, LSB first.
- ANDs the per-bit XNOR results into a single equality flag.
- Sits between client blocks needing word compares and the gate-level XNOR datapath, so only one XNOR instance is built.

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..32.

Ports:
- clk      input   1      single clock, rising edge
- rst      input   1      reset; asynchronous, active-high
- req      input   2      req[i] = requester i wants a compare; held until its done
- a0       input   WIDTH  requester 0 operand A
- b0       input   WIDTH  requester 0 operand B
- a1       input   WIDTH  requester 1 operand A
- b1       input   WIDTH  requester 1 operand B
- gnt      output  2      one-hot grant, asserted from LOAD through DONE
- busy     output  1      high in any state other than IDLE
- done     output  1      one-cycle pulse, result valid
- eq       output  1      1 = operands equal; valid when done=1, held until the next done
- done_id  output  1      requester index owning the current result

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: state=IDLE, gnt=00, busy=0, done=0, eq=0, done_id=0, last_id=1. With last_id=1, requester 0 wins the first tie.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - req=00: stay in IDLE.
  - One request active: select that requester.
  - Both active: select ~last_id.
  - Transition to LOAD with the selected id latched in cur_id.
- LOAD (1 cycle):
  - Capture a/b of cur_id into shift registers sa/sb.
  - acc=1, bit counter cnt=0.
  - gnt[cur_id]=1.
  - Go to SHIFT.
- SHIFT (WIDTH cycles):
  - XNOR cell input is sa[0], sb[0].
  - acc <= acc & xnor_out.
  - sa/sb shift right by one; cnt increments.
  - When cnt==WIDTH-1, go to DONE.
- DONE (1 cycle):
  - done=1, eq=acc (registered), done_id=cur_id.
  - last_id <= cur_id.
  - gnt stays set this cycle.
  - Next state is IDLE.
- Latency: the request sampled in IDLE produces a done pulse exactly WIDTH+2 cycles later (LOAD + WIDTH SHIFT + DONE). Back-to-back grants are separated by one IDLE cycle.
- Operands are sampled only in LOAD. Later changes to a/b, or req being dropped, do not affect the operation in flight; the result is still reported.
- A requester must not reassert req in the DONE cycle expecting a new grant before IDLE. Its req is sampled in the following IDLE.
- Arbitration is fair: with both req held continuously, grants alternate 0,1,0,1...
- rst asserted mid-operation: immediate return to IDLE with all outputs at reset values. The partial result is discarded and no done pulse is produced.
- cnt width is $clog2(WIDTH)+1. No wrap occurs because the FSM leaves SHIFT at WIDTH-1.

Optional Feature:
- Macro: XNOR_CMP_EARLY_EXIT_EN.
- Defined:
  - In SHIFT, a bit with xnor_out=0 sends the FSM straight to DONE next cycle with eq=0.
  - Latency on mismatch is k+3 cycles, where k is the index of the first differing bit.
  - Latency on equality is unchanged at WIDTH+2.
- Undefined: all WIDTH bits are always processed and latency is fixed at WIDTH+2.

Decomposition:
- Shared package/header xnor_cmp_pkg:
  - 2-bit state encoding constants: IDLE=0, LOAD=1, SHIFT=2, DONE=3.
  - Requester-count constant NREQ=2.
  - Default WIDTH.
- Sub-module xnor_nor_cell (output s, input a, input b): the 5-NOR XNOR, purely structural, instantiated once.

Test Plan:
1. Reset, then req=01, a0=8'hA5, b0=8'hA5:
   - gnt=01 from cycle 1.
   - done=1, eq=1, done_id=0 at cycle 10 (WIDTH+2).
   - busy=0 next cycle.
2. req=10, a1=8'h3C, b1=8'h3D (bit 0 differs):
   - Without EN: done at cycle 10, eq=0, done_id=1.
   - With XNOR_CMP_EARLY_EXIT_EN: done at cycle 3, eq=0.
3. req=11 held with equal operands on both requesters:
   - done_id sequence 0,1,0,1.
   - Each done is 11 cycles apart.
4. After LOAD, change a0 from 8'hFF to 8'h00 with b0=8'hFF: done reports eq=1 (operands sampled in LOAD).
5. Assert rst at the 4th SHIFT cycle:
   - All outputs return to reset values asynchronously.
   - No done pulse appears.
   - A fresh req=01 afterwards completes normally in WIDTH+2 cycles.
6. a0=8'h7F, b0=8'hFF (MSB only differs):
   - eq=0 at cycle 10 both with and without EN.
   - Confirms the last bit is accumulated.

Source files
------------

// File: rtl/xnor_cmp_pkg.sv
// Shared constants for the bit-serial XNOR equality scheduler: FSM encoding,
// requester count and default operand width.
package xnor_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NREQ      = 2;
  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/xnor_nor_cell.sv
// Single-bit XNOR built only from two-input NOR gates (five of them).
module xnor_nor_cell (
  output logic s,
  input  logic a,
  input  logic b
);

  logic w_na, w_nb, w_t0, w_t1;

  assign w_na = ~(a | a);
  assign w_nb = ~(b | b);
  // w_t0 = ~a & b, w_t1 = a & ~b; NOR of the two is a XNOR b
  assign w_t0 = ~(a | w_nb);
  assign w_t1 = ~(w_na | b);
  assign s    = ~(w_t0 | w_t1);

endmodule

// File: rtl/xnor_cmp_sched.sv
// Two-requester round-robin front end for one shared bit-serial XNOR comparator.
// Optional: define XNOR_CMP_EARLY_EXIT_EN to finish on the first differing bit.
module xnor_cmp_sched
  import xnor_cmp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             done_id
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           r_state, w_state_nxt;
  logic             r_cur_id, r_last_id, r_eq, r_done_id, r_acc;
  logic [WIDTH-1:0] r_sa, r_sb;
  logic [CW-1:0]    r_cnt;
  logic             w_x, w_acc_nxt, w_sel, w_last_bit;

  xnor_nor_cell u_cell (
    .s (w_x),
    .a (r_sa[0]),
    .b (r_sb[0])
  );

  assign w_acc_nxt  = r_acc & w_x;
  assign w_last_bit = (r_cnt == CW'(WIDTH - 1));
  // On a tie the requester that did not own the previous result wins
  assign w_sel      = (req == 2'b11) ? ~r_last_id : req[1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (|req) w_state_nxt = LOAD;
      LOAD:  w_state_nxt = SHIFT;
      SHIFT: begin
        if (w_last_bit) w_state_nxt = DONE;
`ifdef XNOR_CMP_EARLY_EXIT_EN
        if (!w_x) w_state_nxt = DONE;
`endif
      end
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cur_id  <= 1'b0;
      r_last_id <= 1'b1;
      r_eq      <= 1'b0;
      r_done_id <= 1'b0;
      r_acc     <= 1'b1;
      r_sa      <= '0;
      r_sb      <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (|req) r_cur_id <= w_sel;
        LOAD: begin
          r_sa  <= r_cur_id ? a1 : a0;
          r_sb  <= r_cur_id ? b1 : b0;
          r_acc <= 1'b1;
          r_cnt <= '0;
        end
        SHIFT: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CW'(1);
          // Result is registered on entry to DONE so it holds until the next one
          if (w_state_nxt == DONE) begin
            r_eq      <= w_acc_nxt;
            r_done_id <= r_cur_id;
          end
        end
        DONE: r_last_id <= r_cur_id;
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign gnt     = busy ? (r_cur_id ? 2'b10 : 2'b01) : 2'b00;
  assign eq      = r_eq;
  assign done_id = r_done_id;

endmodule

// File: tb/tb_xnor_cmp_sched.sv
// Randomized self-checking bench for xnor_cmp_sched against a word-level model.
module tb_xnor_cmp_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]   gnt;
  logic         busy, done, eq, done_id;

  int   total = 0;
  int   bad   = 0;
  logic m_last = 1'b1;

  xnor_cmp_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .busy(busy), .done(done), .eq(eq), .done_id(done_id)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef XNOR_CMP_EARLY_EXIT_EN
    for (int k = 0; k < W; k++) if (x[k] != y[k]) return k + 3;
`endif
    return W + 2;
  endfunction

  // One full compare: drive, wait for done, check grant/latency/result/pulse width.
  task automatic do_cmp(input logic [1:0] r, input logic [W-1:0] x0, input logic [W-1:0] y0,
                        input logic [W-1:0] x1, input logic [W-1:0] y1, input bit mutate,
                        input string nm);
    logic         eid;
    logic [W-1:0] ea, eb;
    logic [1:0]   eg;
    int           el, lat;
    bit           seen;
    eid = (r == 2'b11) ? ~m_last : r[1];
    ea  = eid ? x1 : x0;
    eb  = eid ? y1 : y0;
    eg  = eid ? 2'b10 : 2'b01;
    el  = exp_lat(ea, eb);
    a0 = x0; b0 = y0; a1 = x1; b1 = y1; req = r;
    seen = 0; lat = 0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 1) begin
        total++;
        if (gnt !== eg) begin bad++; $display("FAIL %s gnt got=%b exp=%b", nm, gnt, eg); end
      end
      if (mutate && c == 2) a0 = ~a0;
      if (done === 1'b1) begin seen = 1; lat = c; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL %s timeout no done", nm); end
    total++;
    if (lat != el) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", nm, lat, el); end
    total++;
    if (eq !== (ea == eb)) begin bad++; $display("FAIL %s eq got=%b exp=%b", nm, eq, ea == eb); end
    total++;
    if (done_id !== eid) begin bad++; $display("FAIL %s done_id got=%b exp=%b", nm, done_id, eid); end
    m_last = eid;
    req = 2'b00;
    @(posedge clk); @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s after-done got done=%b busy=%b exp 0 0", nm, done, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({gnt, busy, done, eq, done_id} !== 6'b0) begin
      bad++; $display("FAIL reset outputs got=%b exp=000000", {gnt, busy, done, eq, done_id});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_equal();
    do_cmp(2'b01, 8'hA5, 8'hA5, 8'h00, 8'h00, 0, "equal_a5");
  endtask

  task automatic test_mismatch_lsb();
    do_cmp(2'b10, 8'h00, 8'h00, 8'h3C, 8'h3D, 0, "lsb_diff");
  endtask

  task automatic test_mismatch_msb();
    do_cmp(2'b01, 8'h7F, 8'hFF, 8'h00, 8'h00, 0, "msb_diff");
  endtask

  task automatic test_sample_in_load();
    do_cmp(2'b01, 8'hFF, 8'hFF, 8'h00, 8'h00, 1, "sample_load");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v0, v1;
    logic         eid;
    int           prev, nd;
    v0 = W'($urandom); v1 = W'($urandom);
    a0 = v0; b0 = v0; a1 = v1; b1 = v1; req = 2'b11;
    prev = 0; nd = 0;
    for (int c = 1; c <= 100 && nd < 4; c++) begin
      @(posedge clk); @(negedge clk);
      if (done === 1'b1) begin
        eid = ~m_last;
        total++;
        if (done_id !== eid) begin bad++; $display("FAIL b2b done_id got=%b exp=%b", done_id, eid); end
        total++;
        if (eq !== 1'b1) begin bad++; $display("FAIL b2b eq got=%b exp=1", eq); end
        total++;
        if (c - prev != ((nd == 0) ? W + 2 : W + 3)) begin
          bad++; $display("FAIL b2b spacing got=%0d exp=%0d", c - prev, (nd == 0) ? W + 2 : W + 3);
        end
        m_last = eid; prev = c; nd++;
      end
    end
    total++;
    if (nd != 4) begin bad++; $display("FAIL b2b done count got=%0d exp=4", nd); end
    req = 2'b00;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] v;
    v = W'($urandom);
    a0 = v; b0 = v; req = 2'b01;
    for (int c = 1; c <= 5; c++) begin @(posedge clk); @(negedge clk); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({gnt, busy, done, eq, done_id} !== 6'b0) begin
      bad++; $display("FAIL midreset outputs got=%b exp=000000", {gnt, busy, done, eq, done_id});
    end
    req = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL midreset done got=%b exp=0", done); end
    end
    rst = 1'b0;
    m_last = 1'b1;
    @(negedge clk);
    do_cmp(2'b01, v, v, 8'h00, 8'h00, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [1:0]   r;
    logic [W-1:0] x0, y0, x1, y1;
    for (int n = 0; n < 24; n++) begin
      r  = 2'($urandom_range(1, 3));
      x0 = W'($urandom); x1 = W'($urandom);
      y0 = ($urandom_range(0, 2) == 0) ? x0 : x0 ^ (W'(1) << $urandom_range(0, W - 1));
      y1 = ($urandom_range(0, 2) == 0) ? x1 : W'($urandom);
      do_cmp(r, x0, y0, x1, y1, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_mismatch_lsb();
    test_back_to_back();
    test_reset_mid();
    test_mismatch_msb();
    test_sample_in_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
